// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
//   - RISC-V funct3 encodings for loads and stores
//   - controller FSM state type
//   - byte-lane strobe encodings used by the data memory
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RESP
    } state_t;

    localparam logic [3:0] STRB_W  = 4'b1111;
    localparam logic [3:0] STRB_H0 = 4'b0011;
    localparam logic [3:0] STRB_H1 = 4'b1100;
    localparam logic [3:0] STRB_B0 = 4'b0001;
    localparam logic [3:0] STRB_B1 = 4'b0010;
    localparam logic [3:0] STRB_B2 = 4'b0100;
    localparam logic [3:0] STRB_B3 = 4'b1000;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/halfword/word from a
// 32-bit memory word and sign- or zero-extends it according to funct3.
// Ports:
//   mem_rd  - raw 32-bit word read from memory
//   addr    - byte offset within the word
//   funct3  - load type (LB/LH/LW/LBU/LHU)
//   rdata   - right-aligned, extended load result (0 for non-load funct3)
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rd[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    end

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'h000000, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'h0000, half_sel};
            F3_W:    rdata = mem_rd;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the execute stage and a word-addressed data
// memory. One request at a time: IDLE accepts, MEM performs the single-cycle
// access, RESP holds the response until the consumer takes it. Misaligned,
// out-of-range and illegal-funct3 requests skip MEM and answer with resp_err.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                     - request payload
//   resp_valid/resp_ready         - response handshake
//   resp_rdata, resp_err          - response payload
//   mem_we, mem_addr, mem_wdata,
//   mem_strobe                    - memory access (active only in MEM)
//   mem_rd                        - combinational memory read data
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strobe,
    input  logic [31:0] mem_rd
);

    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t      state;
    state_t      state_next;

    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        req_bad;
    logic [31:0] load_data;

    // Request error detection
    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            F3_B:         req_bad = 1'b0;
            F3_H:         req_bad = req_addr[0];
            F3_W:         req_bad = (req_addr[1:0] != 2'b00);
            F3_BU:        req_bad = req_we;
            F3_HU:        req_bad = req_we | req_addr[0];
            default:      req_bad = 1'b1;
        endcase
        if ({1'b0, req_addr} >= ADDR_LIMIT) begin
            req_bad = 1'b1;
        end
    end

    lsu_load_align u_align (
        .mem_rd (mem_rd),
        .addr   (lat_addr[1:0]),
        .funct3 (lat_f3),
        .rdata  (load_data)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = req_bad ? RESP : MEM;
            MEM:  state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_we     = 1'b0;
        mem_strobe = '0;
        if (state == MEM) begin
            // Gate with reset so a reset landing in MEM cannot commit the store.
            mem_we = lat_we & ~reset;
            case (lat_f3)
                F3_W: mem_strobe = STRB_W;
                F3_H, F3_HU: mem_strobe = lat_addr[1] ? STRB_H1 : STRB_H0;
                F3_B, F3_BU: begin
                    case (lat_addr[1:0])
                        2'd0:    mem_strobe = STRB_B0;
                        2'd1:    mem_strobe = STRB_B1;
                        2'd2:    mem_strobe = STRB_B2;
                        default: mem_strobe = STRB_B3;
                    endcase
                end
                default: mem_strobe = '0;
            endcase
        end
    end

    // Request latch and response registers. The memory address/data are only
    // reloaded by requests that will reach MEM, so they hold their last
    // values across errors and idle periods.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we     <= 1'b0;
            lat_f3     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            lat_we    <= req_we;
                            lat_f3    <= req_funct3;
                            lat_addr  <= req_addr;
                            lat_wdata <= req_wdata;
                            resp_err  <= 1'b0;
                        end
                    end
                end
                MEM: begin
                    resp_rdata <= lat_we ? '0 : load_data;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a table of directed load/store
// vectors with hand-computed results, plus sequences for response
// backpressure and reset during the memory cycle. A 64-word memory model,
// word i initialised to i, sits on the memory port.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strobe;
    logic [31:0] mem_rd;

    logic        mem_init;
    logic [31:0] mem [64];

    int n_vec  = 0;
    int n_chk  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DEPTH_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_strobe (mem_strobe),
        .mem_rd     (mem_rd)
    );

    // Memory model: right-aligned write data is steered to the strobed lanes.
    assign mem_rd = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (mem_we) begin
            case (mem_strobe)
                4'b1111: mem[mem_addr[7:2]]        <= mem_wdata;
                4'b0011: mem[mem_addr[7:2]][15:0]  <= mem_wdata[15:0];
                4'b1100: mem[mem_addr[7:2]][31:16] <= mem_wdata[15:0];
                4'b0001: mem[mem_addr[7:2]][7:0]   <= mem_wdata[7:0];
                4'b0010: mem[mem_addr[7:2]][15:8]  <= mem_wdata[7:0];
                4'b0100: mem[mem_addr[7:2]][23:16] <= mem_wdata[7:0];
                4'b1000: mem[mem_addr[7:2]][31:24] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  strb;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with req_ready high (or times out).
    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk({name, " ready wait"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run(input string name, input vec_t v);
        int          lat;
        int          we_cnt;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] mask;
        bit          got;
        wait_ready(name);
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; we_cnt = 0; strb = '0; wd = '0; got = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                wd = mem_wdata;
            end
            if (mem_strobe != 4'b0000) strb = mem_strobe;
            if (resp_valid) begin
                lat = c;
                got = 1'b1;
                break;
            end
        end
        n_vec++;
        chk({name, " resp seen"}, {31'd0, got}, 32'd1);
        chk({name, " latency"}, 32'(lat), v.err ? 32'd1 : 32'd2);
        chk({name, " rdata"}, resp_rdata, v.rdata);
        chk({name, " err"}, {31'd0, resp_err}, {31'd0, v.err});
        chk({name, " strobe"}, {28'd0, strb}, {28'd0, v.strb});
        chk({name, " we count"}, 32'(we_cnt), (v.we && !v.err) ? 32'd1 : 32'd0);
        if (v.we && !v.err) begin
            mask = (v.f3 == 3'b000) ? 32'h0000_00FF :
                   (v.f3 == 3'b001) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            chk({name, " wdata"}, wd & mask, v.wdata & mask);
        end
        @(negedge clk);
        chk({name, " ready after"}, {31'd0, req_ready}, 32'd1);
        chk({name, " resp drop"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        //        we    f3      addr       wdata          rdata          err   strb
        vt[0]  = '{1'b0, 3'b010, 32'h08,  32'h0,          32'h0000_0002, 1'b0, 4'b1111};
        vt[1]  = '{1'b1, 3'b000, 32'h05,  32'h0000_00AB,  32'h0,         1'b0, 4'b0010};
        vt[2]  = '{1'b0, 3'b010, 32'h04,  32'h0,          32'h0000_AB01, 1'b0, 4'b1111};
        vt[3]  = '{1'b0, 3'b000, 32'h05,  32'h0,          32'hFFFF_FFAB, 1'b0, 4'b0010};
        vt[4]  = '{1'b0, 3'b100, 32'h05,  32'h0,          32'h0000_00AB, 1'b0, 4'b0010};
        vt[5]  = '{1'b0, 3'b001, 32'h04,  32'h0,          32'hFFFF_AB01, 1'b0, 4'b0011};
        vt[6]  = '{1'b1, 3'b001, 32'h06,  32'h0000_1234,  32'h0,         1'b0, 4'b1100};
        vt[7]  = '{1'b0, 3'b101, 32'h06,  32'h0,          32'h0000_1234, 1'b0, 4'b1100};
        vt[8]  = '{1'b0, 3'b010, 32'h04,  32'h0,          32'h1234_AB01, 1'b0, 4'b1111};
        vt[9]  = '{1'b1, 3'b010, 32'h0C,  32'hCAFE_F00D,  32'h0,         1'b0, 4'b1111};
        vt[10] = '{1'b0, 3'b000, 32'h0F,  32'h0,          32'hFFFF_FFCA, 1'b0, 4'b1000};
        vt[11] = '{1'b0, 3'b100, 32'h0E,  32'h0,          32'h0000_00FE, 1'b0, 4'b0100};
        vt[12] = '{1'b0, 3'b001, 32'h0E,  32'h0,          32'hFFFF_CAFE, 1'b0, 4'b1100};
        vt[13] = '{1'b0, 3'b000, 32'h0C,  32'h0,          32'h0000_000D, 1'b0, 4'b0001};
        vt[14] = '{1'b0, 3'b010, 32'hFC,  32'h0,          32'h0000_003F, 1'b0, 4'b1111};
        vt[15] = '{1'b1, 3'b001, 32'h03,  32'h0000_5555,  32'h0,         1'b1, 4'b0000};
        vt[16] = '{1'b0, 3'b010, 32'h02,  32'h0,          32'h0,         1'b1, 4'b0000};
        vt[17] = '{1'b0, 3'b010, 32'h100, 32'h0,          32'h0,         1'b1, 4'b0000};
        vt[18] = '{1'b0, 3'b011, 32'h00,  32'h0,          32'h0,         1'b1, 4'b0000};
        vt[19] = '{1'b1, 3'b100, 32'h00,  32'h0000_0077,  32'h0,         1'b1, 4'b0000};
        vt[20] = '{1'b0, 3'b001, 32'h01,  32'h0,          32'h0,         1'b1, 4'b0000};

        reset      = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        mem_init = 1'b0;

        // Reset state
        chk("rst req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata,          32'd0);
        chk("rst resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst mem_we",     {31'd0, mem_we},     32'd0);
        chk("rst mem_strobe", {28'd0, mem_strobe}, 32'd0);
        chk("rst mem_addr",   mem_addr,            32'd0);
        chk("rst mem_wdata",  mem_wdata,           32'd0);

        for (int i = 0; i < NV; i++) begin
            run($sformatf("v%0d", i), vt[i]);
        end

        // Backpressure: response held 3 cycles with a competing request present.
        wait_ready("bp");
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = '0;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        req_addr  = 32'h00;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d resp_valid", k), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp%0d rdata", k),      resp_rdata,          32'h0000_0002);
            chk($sformatf("bp%0d err", k),        {31'd0, resp_err},   32'd0);
            chk($sformatf("bp%0d req_ready", k),  {31'd0, req_ready},  32'd0);
            chk($sformatf("bp%0d mem_we", k),     {31'd0, mem_we},     32'd0);
            chk($sformatf("bp%0d strobe", k),     {28'd0, mem_strobe}, 32'd0);
            if (k < 2) @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp done resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp done req_ready",  {31'd0, req_ready},  32'd1);
        @(negedge clk);
        chk("bp no accept ready", {31'd0, req_ready},  32'd1);
        chk("bp no accept strb",  {28'd0, mem_strobe}, 32'd0);

        // Reset during the MEM cycle of a store: no write, no response.
        wait_ready("rm");
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("rm in MEM strobe", {28'd0, mem_strobe}, 32'h0000_000F);
        reset = 1'b1;
        #1 chk("rm mem_we gated", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rm resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rm req_ready",  {31'd0, req_ready},  32'd1);
        chk("rm resp_rdata", resp_rdata,          32'd0);
        run("rm readback", '{1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_0004, 1'b0, 4'b1111});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that sits between the core's execute stage and the word-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake and decodes RISC-V funct3 into the memory's byte-lane write-strobe encoding. For loads it extracts and sign- or zero-extends the addressed byte, halfword or word. Misaligned and out-of-range accesses are rejected with an error response and never touch memory.

## Interface
- DEPTH_WORDS, 64, number of 32-bit words in the attached memory; byte addresses ≥ DEPTH_WORDS*4 are out of range
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; any other value → error
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_we  out  1  memory write enable
- mem_addr  out  32  byte address to memory (memory indexes addr[31:2])
- mem_wdata  out  32  write data, right-aligned (byte in [7:0], half in [15:0])
- mem_strobe  out  4  lane strobe: 1111 word; 0011/1100 half at offset 0/2; 0001/0010/0100/1000 byte at offset 0/1/2/3
- mem_rd  in  32  combinational read data for mem_addr

## Operation
- FSM states: IDLE, MEM, RESP.
- IDLE: req_ready = 1. On req_valid, latch the request and go to MEM. If the request is in error, latch resp_err = 1 and go straight to RESP instead.
- Error conditions:
  - half access with addr[0] = 1
  - word access with addr[1:0] ≠ 00
  - addr ≥ DEPTH_WORDS*4
  - illegal funct3, including 1xx with req_we = 1
- MEM (exactly one cycle): drive mem_addr, mem_wdata and mem_strobe from the latched request. mem_we = latched we & ~reset.
  - Loads capture the extracted mem_rd into resp_rdata at the end of the cycle.
  - Stores set resp_rdata = 0.
  - Go to RESP.
- RESP: resp_valid = 1. resp_rdata and resp_err stay stable until resp_valid & resp_ready, then go to IDLE. A new request is not accepted in the same cycle.
- Load extraction:
  - byte = mem_rd[8*addr[1:0] +: 8]
  - half = mem_rd[16*addr[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Outside MEM: mem_we = 0 and mem_strobe = 0000. mem_addr and mem_wdata hold their last values.

## Timing
- Reset values: state IDLE, req_ready 1 (from the first cycle after reset), resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_strobe 0000, mem_addr 0, mem_wdata 0.
- Latency with resp_ready held high:
  - accept at edge N, MEM during cycle N+1, resp_valid from N+2, handshake at N+2, req_ready again at N+3.
  - Throughput is one access per 3 cycles.
  - Error requests skip MEM: resp_valid from N+1.
- Backpressure: while RESP is stalled, req_ready = 0 and no memory activity occurs.
- Reset in any state returns to IDLE on that edge. Reset asserted during MEM suppresses the write (mem_we gated), and no response is issued.
- req_valid while req_ready = 0 is ignored. The requester holds it until the handshake.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum (IDLE, MEM, RESP)
  - strobe constants (STRB_W, STRB_H0, STRB_H1, STRB_B0–STRB_B3)
- Sub-module lsu_load_align: combinational; inputs mem_rd, addr[1:0], funct3; output 32-bit extended data. Unit-testable on its own.
- Strobe generation and error detection stay in lsu_mem_ctrl.

## Test plan
The bench memory model initialises word i to value i.
- LW addr 0x08 → resp_rdata 0x00000002, resp_err 0, resp_valid exactly 2 cycles after acceptance.
- SB wdata 0x000000AB addr 0x05 → mem_strobe 0010, mem_wdata[7:0] 0xAB, mem_we high for one cycle. Then LW 0x04 → 0x0000AB01.
- After the SB above: LB 0x05 → 0xFFFFFFAB; LBU 0x05 → 0x000000AB; LH 0x04 → 0xFFFFAB01; SH 0x1234 at 0x06 → mem_strobe 1100.
- Each of SH 0x03, LW 0x02, LW 0x100 (out of range), funct3 011 → resp_err 1, resp_rdata 0, mem_we never asserted, resp_valid 1 cycle after acceptance.
- resp_ready held low for 3 cycles in RESP → resp_valid, resp_rdata and resp_err stable; req_ready 0; a concurrent req_valid is not accepted.
- Reset asserted during the MEM cycle of SW 0xDEADBEEF at 0x10 → no write (word 4 still reads 0x00000004), resp_valid 0, req_ready 1 next cycle.
